// File: rtl/q_func_stream.sv
// Sequential Gaussian tail probability Q(x) engine: Taylor series of erf evaluated term by term
// with a shared multiplier and a bit-serial restoring divider, saturating W-bit fixed point.
module q_func_stream #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int ID_W  = 4,
  parameter int C_INV = 26145
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_x,
  input  logic [7:0]      in_n,
  input  logic [W-1:0]    in_t,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_q,
  output logic [ID_W-1:0] out_id,
  output logic [7:0]      out_terms,
  output logic            out_ovf,
  output logic            busy
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam int XW    = 2 * W + 2;
  localparam logic signed [XW-1:0]  CINV_X   = XW'(C_INV);
  localparam logic signed [W+1:0]   HALF_X   = (W + 2)'(2 ** (FRAC - 1));
  localparam logic signed [W+1:0]   ONE_X    = (W + 2)'(2 ** FRAC);
  localparam logic signed [XW-1:0]  MAX_X    = {{(W + 3){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [XW-1:0]  MIN_X    = {{(W + 3){1'b1}}, {(W - 1){1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SQR, S_MUL, S_DIVK, S_DIVO, S_ACC, S_FIN, S_OUT
  } state_t;

  function automatic logic signed [XW-1:0] sext(input logic [W-1:0] v);
    return {{(W + 2){v[W-1]}}, v};
  endfunction

  // Returns {overflow flag, value clamped to the signed W-bit range}.
  function automatic logic [W:0] sat_w(input logic signed [XW-1:0] v);
    if (v > MAX_X) begin
      return {1'b1, 1'b0, {(W - 1){1'b1}}};
    end else if (v < MIN_X) begin
      return {1'b1, 1'b1, {(W - 1){1'b0}}};
    end else begin
      return {1'b0, v[W-1:0]};
    end
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d, k_q, k_d, terms_q, terms_d;
  logic [W-1:0]      tol_q, tol_d, t_q, t_d, a_q, a_d, s_q, s_d, u_q, u_d, res_q, res_d;
  logic [W-1:0]      dq_q, dq_d, dvs_q, dvs_d;
  logic [W:0]        rem_q, rem_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, dneg_q, dneg_d;

  logic [W:0]        sq_s, mul_s, acc_s, fin_s, rs_s, rem_n_s;
  logic signed [W+1:0] diff_s;
  logic [W-1:0]      qsat_s, dq_n_s, quot_s, uabs_s, pabs_s;
  logic [8:0]        kp1_s;
  logic              ge_s, div_last_s;

  assign sq_s   = sat_w((sext(t_q) * sext(t_q)) >>> (FRAC + 1));
  assign mul_s  = sat_w((sext(t_q) * sext(a_q)) >>> FRAC);
  assign acc_s  = sat_w(sext(s_q) + sext(u_q));
  assign fin_s  = sat_w((sext(s_q) * CINV_X) >>> FRAC);
  assign diff_s = HALF_X - {{2{fin_s[W-1]}}, fin_s[W-1:0]};
  assign pabs_s = mul_s[W-1] ? ({W{1'b0}} - mul_s[W-1:0]) : mul_s[W-1:0];
  assign uabs_s = u_q[W-1] ? ({W{1'b0}} - u_q) : u_q;
  assign kp1_s  = {1'b0, k_q} + 9'd1;

  // One restoring-division step on magnitudes; sign is reapplied so the quotient truncates toward zero.
  assign rs_s       = {rem_q[W-1:0], dq_q[W-1]};
  assign ge_s       = rem_q[W] | (rs_s >= {1'b0, dvs_q});
  assign rem_n_s    = ge_s ? (rs_s - {1'b0, dvs_q}) : rs_s;
  assign dq_n_s     = {dq_q[W-2:0], ge_s};
  assign quot_s     = dneg_q ? ({W{1'b0}} - dq_n_s) : dq_n_s;
  assign div_last_s = (cnt_q == CNT_LAST);

  // Final result clamped to the probability range [0, 1.0].
  always_comb begin
    if (diff_s[W+1]) begin
      qsat_s = {W{1'b0}};
    end else if (diff_s > ONE_X) begin
      qsat_s = ONE_X[W-1:0];
    end else begin
      qsat_s = diff_s[W-1:0];
    end
  end

  // Next-state and datapath update for the series FSM.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    terms_d = terms_q;
    tol_d   = tol_q;
    t_d     = t_q;
    a_d     = a_q;
    s_d     = s_q;
    u_d     = u_q;
    res_d   = res_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dneg_d  = dneg_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          t_d     = in_x;
          tol_d   = in_t;
          id_d    = in_id;
          ovf_d   = 1'b0;
          terms_d = 8'd0;
          state_d = S_SQR;
          if (in_n == 8'd0) begin
            n_d = 8'd1;
          end else begin
            n_d = in_n;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SQR: begin
        a_d     = {W{1'b0}} - sq_s[W-1:0];
        ovf_d   = ovf_q | sq_s[W];
        s_d     = t_q;
        k_d     = 8'd1;
        terms_d = 8'd1;
        if (n_q <= 8'd1) begin
          state_d = S_FIN;
        end else begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        ovf_d   = ovf_q | mul_s[W];
        dq_d    = pabs_s;
        dneg_d  = mul_s[W-1];
        rem_d   = {(W + 1){1'b0}};
        dvs_d   = {{(W - 8){1'b0}}, k_q};
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_DIVK;
      end
      S_DIVK: begin
        if (div_last_s) begin
          t_d     = quot_s;
          dq_d    = dq_n_s;
          rem_d   = {(W + 1){1'b0}};
          dvs_d   = {{(W - 9){1'b0}}, k_q, 1'b1};
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_DIVO;
        end else begin
          dq_d  = dq_n_s;
          rem_d = rem_n_s;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DIVO: begin
        if (div_last_s) begin
          u_d     = quot_s;
          state_d = S_ACC;
        end else begin
          dq_d  = dq_n_s;
          rem_d = rem_n_s;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ACC: begin
        s_d     = acc_s[W-1:0];
        ovf_d   = ovf_q | acc_s[W];
        terms_d = kp1_s[7:0];
        k_d     = kp1_s[7:0];
        if ((kp1_s >= {1'b0, n_q}) || ((tol_q != {W{1'b0}}) && (uabs_s < tol_q))) begin
          state_d = S_FIN;
        end else begin
          state_d = S_MUL;
        end
      end
      S_FIN: begin
        res_d   = qsat_s;
        ovf_d   = ovf_q | fin_s[W];
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= 8'd0;
      k_q     <= 8'd0;
      terms_q <= 8'd0;
      tol_q   <= {W{1'b0}};
      t_q     <= {W{1'b0}};
      a_q     <= {W{1'b0}};
      s_q     <= {W{1'b0}};
      u_q     <= {W{1'b0}};
      res_q   <= {W{1'b0}};
      dq_q    <= {W{1'b0}};
      dvs_q   <= {W{1'b0}};
      rem_q   <= {(W + 1){1'b0}};
      id_q    <= {ID_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      dneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      terms_q <= terms_d;
      tol_q   <= tol_d;
      t_q     <= t_d;
      a_q     <= a_d;
      s_q     <= s_d;
      u_q     <= u_d;
      res_q   <= res_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dneg_q  <= dneg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_q     = res_q;
  assign out_id    = id_q;
  assign out_terms = terms_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_q_func_stream.sv
// Bench for q_func_stream: fixed vectors, handshake/reset corner sequences, and randomized
// requests checked against an integer-arithmetic model of the Q(x) series.
module tb_q_func_stream;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
  logic [31:0] in_x, in_t, out_q;
  logic [7:0]  in_n, out_terms;
  logic [3:0]  in_id, out_id;

  int n_vec  = 0;
  int n_miss = 0;
  bit overlap = 1'b0;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483647 - 64'sd1;

  q_func_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_n(in_n), .in_t(in_t), .in_id(in_id), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_id(out_id), .out_terms(out_terms), .out_ovf(out_ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] x; logic [7:0] n; logic [31:0] t; logic [3:0] id;
    logic [31:0] q; logic [7:0] terms; logic ovf; int lat;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic longint clip(input longint v);
    if (v > MAXV) return MAXV;
    else if (v < MINV) return MINV;
    else return v;
  endfunction

  // Reference: Q(x) = 1/2 - C*sum_k u_k with saturating integer arithmetic.
  task automatic model(input int x, input int n, input int tol, output longint q,
                       output longint terms, output bit ovf, output int lat);
    longint raw, a, t, s, p, u, k, nn, f, d, tl, au;
    bit stop;
    ovf = 1'b0;
    nn  = (n == 0) ? 1 : n;
    tl  = longint'(tol) & 64'hFFFF_FFFF;
    raw = (longint'(x) * longint'(x)) >>> 17;
    a = clip(raw); if (a != raw) ovf = 1'b1;
    a = -a;
    t = x; s = x; k = 1; terms = 1;
    stop = (nn <= 1);
    while (!stop) begin
      raw = (t * a) >>> 16;
      p = clip(raw); if (p != raw) ovf = 1'b1;
      t = p / k;
      u = t / (2 * k + 1);
      raw = s + u;
      s = clip(raw); if (s != raw) ovf = 1'b1;
      k = k + 1;
      terms = k;
      au = (u < 0) ? -u : u;
      stop = (k >= nn) || (tl != 0 && au < tl);
    end
    raw = (s * 26145) >>> 16;
    f = clip(raw); if (f != raw) ovf = 1'b1;
    d = 32768 - f;
    if (d < 0) q = 0;
    else if (d > 65536) q = 65536;
    else q = d;
    lat = 2 + int'(terms - 1) * 66;
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    while (!ok && lat < 20000) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready && out_valid) overlap = 1'b1;
      if (out_valid) ok = 1'b1;
    end
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] x, input logic [7:0] n, input logic [31:0] t,
                        input logic [3:0] id, input int hold,
                        output logic [31:0] q, output logic [3:0] oid, output logic [7:0] terms,
                        output logic ovf, output int lat, output bit ok);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    in_x = x; in_n = n; in_t = t; in_id = id; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat, ok);
    q = out_q; oid = out_id; terms = out_terms; ovf = out_ovf;
    if (ok) release_out(hold);
  endtask

  initial begin
    vec_t        tbl[6];
    logic [31:0] q;
    logic [3:0]  oid;
    logic [7:0]  terms;
    logic        ovf;
    int          lat;
    bit          ok, seen;
    longint      mq, mterms;
    bit          movf;
    int          mlat;

    tbl[0] = '{32'h0000_0000, 8'd1,  32'd0, 4'd3, 32'h0000_8000, 8'd1, 1'b0, 2};
    tbl[1] = '{32'h0001_0000, 8'd1,  32'd0, 4'd4, 32'h0000_19DF, 8'd1, 1'b0, 2};
    tbl[2] = '{32'h0001_0000, 8'd2,  32'd0, 4'd5, 32'h0000_2AE5, 8'd2, 1'b0, 68};
    tbl[3] = '{32'h0000_0000, 8'd20, 32'd1, 4'd6, 32'h0000_8000, 8'd2, 1'b0, 68};
    tbl[4] = '{32'h0001_0000, 8'd0,  32'd0, 4'd7, 32'h0000_19DF, 8'd1, 1'b0, 2};
    tbl[5] = '{32'h8000_0000, 8'd1,  32'd0, 4'd8, 32'h0001_0000, 8'd1, 1'b1, 2};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = 32'd0; in_n = 8'd0; in_t = 32'd0; in_id = 4'd0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {out_q, out_id, out_terms, out_ovf}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      do_req(tbl[i].x, tbl[i].n, tbl[i].t, tbl[i].id, i % 3, q, oid, terms, ovf, lat, ok);
      chk($sformatf("vec%0d_done", i), ok, 1);
      chk($sformatf("vec%0d_q", i), q, tbl[i].q);
      chk($sformatf("vec%0d_id", i), oid, tbl[i].id);
      chk($sformatf("vec%0d_terms", i), terms, tbl[i].terms);
      chk($sformatf("vec%0d_ovf", i), ovf, tbl[i].ovf);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end

    // Back-pressure: outputs hold, new request waits until the cycle after the handshake.
    in_x = 32'h0001_0000; in_n = 8'd2; in_t = 32'd0; in_id = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_x = 32'd0; in_n = 8'd1; in_id = 4'd6;
    wait_out(lat, ok);
    chk("bp_done", ok, 1);
    chk("bp_lat", lat, 68);
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold", {out_valid, in_ready, out_id, out_q}, {1'b1, 1'b0, 4'd5, 32'h0000_2AE5});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_after_hs", {in_ready, out_valid}, {1'b1, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", {busy, in_ready}, {1'b1, 1'b0});
    wait_out(lat, ok);
    chk("bp2_lat", lat, 2);
    chk("bp2_res", {out_id, out_q}, {4'd6, 32'h0000_8000});
    release_out(0);

    // Reset in the middle of the first division phase.
    in_x = 32'h0001_0000; in_n = 8'd5; in_t = 32'd0; in_id = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", {busy, out_valid, out_q, out_id, out_terms, out_ovf}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", seen, 0);
    do_req(32'h0001_0000, 8'd2, 32'd0, 4'd9, 1, q, oid, terms, ovf, lat, ok);
    chk("post_rst_done", ok, 1);
    chk("post_rst_res", {oid, q, terms}, {4'd9, 32'h0000_2AE5, 8'd2});
    chk("post_rst_lat", lat, 68);

    // Randomized requests against the model.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] rx, rt;
      logic [7:0]  rn;
      logic [3:0]  rid;
      if (i % 7 == 0) rx = $urandom;
      else rx = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      rn  = 8'($urandom_range(0, 10));
      rt  = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
      rid = 4'($urandom_range(0, 15));
      model(int'(rx), int'(rn), int'(rt), mq, mterms, movf, mlat);
      do_req(rx, rn, rt, rid, int'($urandom_range(0, 3)), q, oid, terms, ovf, lat, ok);
      chk($sformatf("rnd%0d_done", i), ok, 1);
      chk($sformatf("rnd%0d_q x=%0h n=%0d t=%0d", i, rx, rn, rt), q, mq);
      chk($sformatf("rnd%0d_id", i), oid, rid);
      chk($sformatf("rnd%0d_terms", i), terms, mterms);
      chk($sformatf("rnd%0d_ovf", i), ovf, movf);
      chk($sformatf("rnd%0d_lat", i), lat, mlat);
    end

    chk("ready_valid_exclusive", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
